// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier controller feeding an external 2*WIDTH adder.
// One multiplier bit per cycle; product registered with a one-cycle done pulse.
module shift_add_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] add_a,
  output logic [2*WIDTH-1:0] add_b,
  input  logic [2*WIDTH-1:0] add_sum
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_prod;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic             w_bit;
  logic [PW-1:0]    w_add_a;
  logic [PW-1:0]    w_add_b;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_bit  = r_mplier[r_cnt[IW-1:0]];

  always_comb begin
    w_next  = r_state;
    w_add_a = '0;
    w_add_b = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ADD;
      end
      S_ADD: begin
        w_add_a = r_acc;
        w_add_b = w_bit ? (r_mcand << r_cnt) : '0;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      // status flags follow the next state so they are registered, not decoded
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= PW'(multiplicand);
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_ADD: begin
          r_acc <= add_sum;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_prod <= add_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_prod;
  assign add_a   = w_add_a;
  assign add_b   = w_add_b;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Self-checking bench for shift_add_mult_seq with a behavioural adder
// and plain-arithmetic reference products.
module tb_shift_add_mult_seq;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [PW-1:0] add_a;
  logic [PW-1:0] add_b;
  logic [PW-1:0] add_sum;

  int n_checks = 0;
  int n_fail   = 0;

  assign add_sum = add_a + add_b;

  shift_add_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
  endtask

  task automatic wait_done(input bit hold, output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (product !== '0 || add_a !== '0 || add_b !== '0) begin
      n_fail++;
      $display("FAIL reset_data: product=%h add_a=%h add_b=%h required 0",
               product, add_a, add_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    launch(8'd200, 8'd100);
    wait_done(1'b0, n);
    n_checks++;
    if (n !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles required 9", n);
    end
    n_checks++;
    if (product !== 16'h4E20 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_product: got %h busy=%b required 4e20 busy=1",
               product, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h4E20) begin
      n_fail++;
      $display("FAIL basic_after: done=%b busy=%b product=%h required 0 0 4e20",
               done, busy, product);
    end
  endtask

  task automatic test_max;
    logic [PW-1:0] exp_b;
    logic [PW-1:0] exp_a;
    launch(8'hFF, 8'hFF);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_b = PW'(16'h00FF << i);
      exp_a = PW'(255 * ((1 << i) - 1));
      n_checks++;
      if (add_b !== exp_b || add_a !== exp_a) begin
        n_fail++;
        $display("FAIL max_step%0d: add_a=%h add_b=%h required %h %h",
                 i, add_a, add_b, exp_a, exp_b);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL max_product: done=%b product=%h required 1 fe01",
               done, product);
    end
    n_checks++;
    if (add_a !== '0 || add_b !== '0) begin
      n_fail++;
      $display("FAIL max_done_bus: add_a=%h add_b=%h required 0 0", add_a, add_b);
    end
    @(negedge clk);
  endtask

  task automatic test_zero;
    int n;
    logic [W-1:0] a_v [2];
    logic [W-1:0] b_v [2];
    a_v[0] = 8'h37; b_v[0] = 8'h00;
    a_v[1] = 8'h00; b_v[1] = 8'h37;
    for (int k = 0; k < 2; k++) begin
      launch(a_v[k], b_v[k]);
      wait_done(1'b0, n);
      n_checks++;
      if (n !== 9 || product !== '0) begin
        n_fail++;
        $display("FAIL zero_%0d: cycles=%0d product=%h required 9 0",
                 k, n, product);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    logic [PW-1:0] seen = '0;
    launch(8'd3, 8'd5);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) launch(8'd9, 8'd9);
      if (c >= 5) begin
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
      end
      if (done) begin
        dones++;
        seen = product;
      end
    end
    n_checks++;
    if (dones !== 1 || seen !== 16'd15) begin
      n_fail++;
      $display("FAIL busy_ignore: dones=%0d product=%0d required 1 15",
               dones, seen);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int dones = 0;
    launch(8'd100, 8'd7);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || add_a !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h add_a=%h required 0",
               busy, done, product, add_a);
    end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || busy !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: dones=%0d busy=%b product=%h required 0",
               dones, busy, product);
    end
    launch(8'd12, 8'd12);
    wait_done(1'b0, n);
    n_checks++;
    if (n !== 9 || product !== 16'd144) begin
      n_fail++;
      $display("FAIL reset_recover: cycles=%0d product=%0d required 9 144",
               n, product);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    int exp_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [PW-1:0] exp_p;
    a = W'($urandom);
    b = W'($urandom);
    launch(a, b);
    for (int r = 0; r < 100; r++) begin
      exp_n = (r == 0) ? 9 : 10;
      exp_p = PW'(a) * PW'(b);
      wait_done(1'b1, n);
      n_checks++;
      if (n !== exp_n || product !== exp_p) begin
        n_fail++;
        $display("FAIL b2b_run%0d: cycles=%0d product=%h required %0d %h",
                 r, n, product, exp_n, exp_p);
      end
      a = W'($urandom);
      b = W'($urandom);
      multiplicand = a;
      multiplier   = b;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
